core_management_wishbone_bridge: RTL
====================================

# core_management_wishbone_bridge

Wishbone classic slave that turns bus cycles from the caravel-side Wishbone interconnect into single-request transactions on the core management port (`wb_management_*`). The port arbiter gives JTAG priority and raises `wb_management_busy`. While busy is high, this bridge holds its request stable. It completes the Wishbone cycle with `wb_ack_o` once the arbiter accepts the request. If the request is still not accepted after a bounded number of cycles, it completes the cycle with `wb_error_o` instead.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: number of consecutive busy cycles in REQUEST before the bridge aborts with an error. Range 1..255. Counter is 8 bits.

Ports (reset rst, synchronous, active-high; clock clk):
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `wb_cyc_i`  in  1  Wishbone cycle
- `wb_stb_i`  in  1  Wishbone strobe
- `wb_we_i`  in  1  write (1) / read (0)
- `wb_sel_i`  in  4  byte lanes
- `wb_adr_i`  in  24  byte address
- `wb_data_i`  in  32  write data
- `enable`  in  1  region decode from the interconnect; the cycle targets this bridge
- `wb_ack_o`  out  1  cycle complete, success
- `wb_error_o`  out  1  cycle complete, timeout
- `wb_data_o`  out  32  read data
- `wb_management_writeEnable`  out  1  write request to the management port
- `wb_management_readEnable`  out  1  read request to the management port
- `wb_management_byteSelect`  out  4  latched `wb_sel_i`
- `wb_management_address`  out  20  latched `wb_adr_i[19:0]`
- `wb_management_writeData`  out  32  latched `wb_data_i`
- `wb_management_readData`  in  32  combinational read data from the management port
- `wb_management_busy`  in  1  arbiter is serving JTAG; request not accepted this cycle

## Operation
- FSM states: IDLE, REQUEST, ACK, ERROR. Reset enters IDLE.
- IDLE:
  - When `wb_cyc_i && wb_stb_i && enable`: latch `we`, `sel`, `adr[19:0]` and `data`, clear the busy counter, go to REQUEST.
  - All management enables are 0 in IDLE.
- REQUEST:
  - Drive `wb_management_writeEnable = we_latched` and `wb_management_readEnable = !we_latched` from registered state.
  - Address, byteSelect and writeData come from the latches and do not change.
  - If `!wb_cyc_i`: the master aborted. Go to IDLE; no ack, no error.
  - Else if `!wb_management_busy`: the request is accepted this cycle. For reads, capture `wb_management_readData` into `wb_data_o`. Go to ACK.
  - Else if the counter equals `TIMEOUT_CYCLES-1`: go to ERROR.
  - Else: increment the counter and stay in REQUEST.
- ACK: `wb_ack_o = 1` for exactly one cycle, then go to IDLE regardless of `wb_stb_i`. The master drops stb after seeing ack.
- ERROR: `wb_error_o = 1` for exactly one cycle, `wb_data_o = 32'hFFFF_FFFF`, then go to IDLE.
- `wb_ack_o` and `wb_error_o` are never high together.
- Outputs are driven only while `enable` was seen at request start. Other bus slaves are unaffected.
- A write may see the enable high for several busy cycles. The write takes effect only on the accepted cycle, because the arbiter masks it while busy.
- `wb_data_o`:
  - Holds its last value outside ACK/ERROR.
  - Is don't-care on write acks; it is held unchanged.
- Bits `wb_adr_i[23:20]` are ignored; region decode is the interconnect's job via `enable`.

## Timing
- Reset values: all outputs 0. `wb_data_o = 0`, state IDLE, counter 0.
- Reset asserted mid-transaction: next cycle in IDLE, enables 0, no ack or error issued.
- Request sampled at edge N:
  - Management enable is high in cycle N+1.
  - If not busy in N+1: read data is captured at edge N+2 and `wb_ack_o` is high during cycle N+2.
  - Minimum latency is 2 cycles from the sampling edge to ack.
- Each busy cycle adds one cycle of latency.
- With k busy cycles (k < `TIMEOUT_CYCLES`), ack is high in cycle N+2+k.
- With `TIMEOUT_CYCLES` consecutive busy cycles, `wb_error_o` is high in cycle N+1+`TIMEOUT_CYCLES`.
- Back-to-back: after ack in cycle M, the bridge is in IDLE in M+1 and can sample a new request at edge M+1 → ack no earlier than M+3.
- Busy dropping in the same cycle that the counter reaches the limit: acceptance wins → ACK.
- `wb_cyc_i` low and busy low in the same REQUEST cycle: abort wins → IDLE, no ack.

## Test plan
- Single read: addr 0x000004, busy=0, readData=0x0000_0013 → readEnable high 1 cycle, `wb_ack_o` 2 cycles after the stb edge, `wb_data_o`=0x13.
- Single write: addr 0x010040, sel=4'b0011, data=0xDEAD_BEEF, busy=0 → writeEnable high exactly 1 cycle with address 0x10040, byteSelect 0x3, writeData 0xDEADBEEF; ack 2 cycles after the stb edge.
- JTAG contention: busy held high 5 cycles after the request → enable high 6 cycles with stable address and data, read data captured on the 6th, ack at N+7.
- Timeout with `TIMEOUT_CYCLES`=8 and busy stuck high → `wb_error_o` for 1 cycle at N+9, `wb_data_o`=0xFFFFFFFF, no ack, enables 0 afterwards.
- Abort and reset: `wb_cyc_i` dropped during busy → IDLE next cycle, no ack. `rst` pulsed in REQUEST → all outputs 0 next cycle.
- Back-to-back writes then read with `enable` toggled low for an intervening cycle → the unselected cycle gets no response; the selected ones ack in order with correct data.

Source files
------------

// File: rtl/core_management_wishbone_bridge.sv
// core_management_wishbone_bridge: Wishbone classic slave forwarding single requests to the core management port
module core_management_wishbone_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [23:0] wb_adr_i,
    input  logic [31:0] wb_data_i,
    input  logic        enable,
    output logic        wb_ack_o,
    output logic        wb_error_o,
    output logic [31:0] wb_data_o,
    output logic        wb_management_writeEnable,
    output logic        wb_management_readEnable,
    output logic [3:0]  wb_management_byteSelect,
    output logic [19:0] wb_management_address,
    output logic [31:0] wb_management_writeData,
    input  logic [31:0] wb_management_readData,
    input  logic        wb_management_busy
);
    typedef enum logic [1:0] {IDLE, REQUEST, ACK, ERROR} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [19:0] adr_q;
    logic [31:0] wdat_q, rdat_q;
    logic        start, limit, unused_adr;
    assign start = wb_cyc_i && wb_stb_i && enable;
    assign limit = cnt_q == 8'(TIMEOUT_CYCLES - 1);
    // Upper address bits belong to the interconnect's region decode
    assign unused_adr = ^wb_adr_i[23:20];
    // State register
    always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
    // Next state: abort beats acceptance, acceptance beats timeout
    always_comb begin
        state_d = IDLE;
        if (state_q == IDLE)
            state_d = start ? REQUEST : IDLE;
        else if (state_q == REQUEST)
            state_d = !wb_cyc_i ? IDLE : !wb_management_busy ? ACK : limit ? ERROR : REQUEST;
    end
    // Request latches, busy counter and read-data register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            adr_q  <= '0;
            wdat_q <= '0;
            rdat_q <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                cnt_q  <= '0;
                we_q   <= wb_we_i;
                sel_q  <= wb_sel_i;
                adr_q  <= wb_adr_i[19:0];
                wdat_q <= wb_data_i;
            end
            if (state_q == REQUEST && state_d == REQUEST) cnt_q <= cnt_q + 8'd1;
            if (state_q == REQUEST && state_d == ACK && !we_q) rdat_q <= wb_management_readData;
            if (state_q == REQUEST && state_d == ERROR) rdat_q <= '1;
        end
    end
    // Outputs decoded from registered state only
    always_comb begin
        wb_ack_o                  = state_q == ACK;
        wb_error_o                = state_q == ERROR;
        wb_management_writeEnable = state_q == REQUEST && we_q;
        wb_management_readEnable  = state_q == REQUEST && !we_q;
    end
    assign wb_data_o                = rdat_q;
    assign wb_management_byteSelect = sel_q;
    assign wb_management_address    = adr_q;
    assign wb_management_writeData  = wdat_q;
endmodule
